// File: rtl/vc_demux2_tdm.sv
// Two-domain TDM demultiplexer: ring-egress messages are accepted on a fixed
// slot schedule and steered into one 2-entry queue per domain.
module vc_demux2_tdm #(
  parameter int p_nbits       = 32,
  parameter int p_slot_cycles = 4
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  logic               in_domain,
  output logic               slot_domain,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg
);

  localparam int cw = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam logic [cw-1:0] slot_last = cw'(p_slot_cycles - 1);

  logic [cw-1:0]      slot_cnt_r;
  logic               slot_domain_r;
  logic [p_nbits-1:0] mem_r [2][2];
  logic [1:0]         head_r;
  logic [1:0]         tail_r;
  logic [1:0]         cnt_r [2];
  logic [1:0]         enq_s;
  logic [1:0]         deq_s;
  logic [1:0]         rdy_s;
  logic               in_rdy_s;

  // Slot schedule: free-running, independent of traffic and backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r    <= {cw{1'b0}};
      slot_domain_r <= 1'b0;
    end else if (slot_cnt_r == slot_last) begin
      slot_cnt_r    <= {cw{1'b0}};
      slot_domain_r <= ~slot_domain_r;
    end else begin
      slot_cnt_r    <= slot_cnt_r + cw'(1);
    end
  end

  // Acceptance looks only at the slot owner's queue, using the pre-dequeue count.
  always_comb begin
    in_rdy_s = (in_domain == slot_domain_r) && (cnt_r[slot_domain_r] != 2'd2);
    rdy_s    = {out1_rdy, out0_rdy};
    for (int d = 0; d < 2; d++) begin
      enq_s[d] = in_val && in_rdy_s && (slot_domain_r == d[0]);
      deq_s[d] = (cnt_r[d] != 2'd0) && rdy_s[d];
    end
  end

  // Queue pointers and occupancy for both domains.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r <= 2'b00;
      tail_r <= 2'b00;
      for (int d = 0; d < 2; d++) begin
        cnt_r[d] <= 2'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (enq_s[d]) begin
          tail_r[d] <= ~tail_r[d];
        end
        if (deq_s[d]) begin
          head_r[d] <= ~head_r[d];
        end
        case ({enq_s[d], deq_s[d]})
          2'b10:   cnt_r[d] <= cnt_r[d] + 2'd1;
          2'b01:   cnt_r[d] <= cnt_r[d] - 2'd1;
          default: cnt_r[d] <= cnt_r[d];
        endcase
      end
    end
  end

  // Payload storage; contents are only meaningful while the count covers them.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (enq_s[d]) begin
        mem_r[d][tail_r[d]] <= in_msg;
      end
    end
  end

  assign in_rdy      = in_rdy_s;
  assign slot_domain = slot_domain_r;
  assign out0_val    = (cnt_r[0] != 2'd0);
  assign out1_val    = (cnt_r[1] != 2'd0);
  assign out0_msg    = mem_r[0][head_r[0]];
  assign out1_msg    = mem_r[1][head_r[1]];

endmodule

// File: tb/tb_vc_demux2_tdm.sv
// Bench for vc_demux2_tdm: directed cycle table with constant expectations,
// then a random phase against a slot/queue model, both feeding a scoreboard.
module tb_vc_demux2_tdm;

  localparam int nb = 32;
  localparam int ps = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [nb-1:0] in_msg = 32'h0;
  logic          in_domain = 1'b0;
  logic          slot_domain;
  logic          out0_val, out1_val;
  logic          out0_rdy = 1'b0, out1_rdy = 1'b0;
  logic [nb-1:0] out0_msg, out1_msg;

  int errors = 0;
  int checks = 0;

  logic [nb-1:0] q0[$];
  logic [nb-1:0] q1[$];

  // ctl = {rst, in_val, in_domain, out0_rdy, out1_rdy}; ex = {in_rdy, slot, v0, v1}
  typedef struct {
    logic [4:0]    ctl;
    logic [nb-1:0] msg;
    logic [3:0]    ex;
    logic [nb-1:0] m0;
    logic [nb-1:0] m1;
  } vec_t;
  vec_t tbl[$];

  vc_demux2_tdm #(.p_nbits(nb), .p_slot_cycles(ps)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_domain(in_domain),
    .slot_domain(slot_domain),
    .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg),
    .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [nb-1:0] act, input logic [nb-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] ctl, input logic [nb-1:0] msg, input logic [3:0] ex,
                     input logic [nb-1:0] m0, input logic [nb-1:0] m1);
    vec_t v;
    v.ctl = ctl; v.msg = msg; v.ex = ex; v.m0 = m0; v.m1 = m1;
    tbl.push_back(v);
  endtask

  // One cycle: drive at negedge, check just after, then update the scoreboard.
  task automatic cyc(input string tag, input logic [4:0] ctl, input logic [nb-1:0] msg,
                     input logic [3:0] ex, input logic [nb-1:0] m0, input logic [nb-1:0] m1);
    @(negedge clk);
    reset = ctl[4]; in_val = ctl[3]; in_domain = ctl[2]; out0_rdy = ctl[1]; out1_rdy = ctl[0];
    in_msg = msg;
    #1;
    chk({tag, " in_rdy"}, {31'h0, in_rdy}, {31'h0, ex[3]});
    chk({tag, " slot_domain"}, {31'h0, slot_domain}, {31'h0, ex[2]});
    chk({tag, " out0_val"}, {31'h0, out0_val}, {31'h0, ex[1]});
    chk({tag, " out1_val"}, {31'h0, out1_val}, {31'h0, ex[0]});
    if (ex[1]) chk({tag, " out0_msg"}, out0_msg, m0);
    if (ex[0]) chk({tag, " out1_msg"}, out1_msg, m1);
    if (ex[1] && ctl[1]) begin
      if (q0.size() == 0) chk({tag, " sb0 underflow"}, 32'h1, 32'h0);
      else chk({tag, " sb0 order"}, out0_msg, q0.pop_front());
    end
    if (ex[0] && ctl[0]) begin
      if (q1.size() == 0) chk({tag, " sb1 underflow"}, 32'h1, 32'h0);
      else chk({tag, " sb1 order"}, out1_msg, q1.pop_front());
    end
    if (ctl[4]) begin
      q0.delete();
      q1.delete();
    end else if (ctl[3] && ex[3]) begin
      if (ctl[2]) q1.push_back(msg);
      else q0.push_back(msg);
    end
  endtask

  initial begin
    int m_cnt;
    logic m_slot;
    logic s;

    // Idle after reset: four cycles per domain, queues empty.
    for (int i = 0; i < 9; i++) begin
      s = 1'((i / 4) % 2);
      add(5'b00000, 32'h0, {~s, s, 2'b00}, 32'h0, 32'h0);
    end
    add(5'b10000, 32'h0, 4'b1000, 32'h0, 32'h0);
    // Domain-0 fill to full, dequeue at full, then enqueue+dequeue at count 1.
    add(5'b01000, 32'hA0, 4'b1000, 32'h0,  32'h0);
    add(5'b01000, 32'hA1, 4'b1010, 32'hA0, 32'h0);
    add(5'b01000, 32'hA2, 4'b0010, 32'hA0, 32'h0);
    add(5'b01010, 32'hA2, 4'b0010, 32'hA0, 32'h0);
    for (int i = 0; i < 4; i++) add(5'b00000, 32'h0, 4'b0110, 32'hA1, 32'h0);
    add(5'b01010, 32'hC1, 4'b1010, 32'hA1, 32'h0);
    add(5'b00000, 32'h0,  4'b1010, 32'hC1, 32'h0);
    add(5'b00010, 32'h0,  4'b1010, 32'hC1, 32'h0);
    add(5'b00000, 32'h0,  4'b1000, 32'h0,  32'h0);
    add(5'b10000, 32'h0,  4'b0100, 32'h0,  32'h0);
    // Domain-1 message waits for its slot.
    for (int i = 0; i < 4; i++) add(5'b01100, 32'hB0, 4'b0000, 32'h0, 32'h0);
    add(5'b01100, 32'hB0, 4'b1100, 32'h0, 32'h0);
    add(5'b00100, 32'h0,  4'b1101, 32'h0, 32'hB0);
    add(5'b00101, 32'h0,  4'b1101, 32'h0, 32'hB0);
    add(5'b00100, 32'h0,  4'b1100, 32'h0, 32'h0);
    add(5'b10100, 32'h0,  4'b0000, 32'h0, 32'h0);
    // Domain 0 held full while domain 1 streams through its slot.
    add(5'b01000, 32'hA0, 4'b1000, 32'h0,  32'h0);
    add(5'b01000, 32'hA1, 4'b1010, 32'hA0, 32'h0);
    add(5'b00100, 32'h0,  4'b0010, 32'hA0, 32'h0);
    add(5'b00100, 32'h0,  4'b0010, 32'hA0, 32'h0);
    add(5'b01101, 32'hB0, 4'b1110, 32'hA0, 32'h0);
    add(5'b01101, 32'hB1, 4'b1111, 32'hA0, 32'hB0);
    add(5'b01101, 32'hB2, 4'b1111, 32'hA0, 32'hB1);
    add(5'b01101, 32'hB3, 4'b1111, 32'hA0, 32'hB2);
    add(5'b00101, 32'h0,  4'b0011, 32'hA0, 32'hB3);
    add(5'b00001, 32'h0,  4'b0010, 32'hA0, 32'h0);
    add(5'b10000, 32'h0,  4'b0010, 32'hA0, 32'h0);
    // Reset mid-slot with both queues occupied; schedule restarts at domain 0.
    add(5'b01000, 32'hE0, 4'b1000, 32'h0,  32'h0);
    for (int i = 0; i < 3; i++) add(5'b00100, 32'h0, 4'b0010, 32'hE0, 32'h0);
    add(5'b01100, 32'hF0, 4'b1110, 32'hE0, 32'h0);
    add(5'b00100, 32'h0,  4'b1111, 32'hE0, 32'hF0);
    add(5'b10100, 32'h0,  4'b1111, 32'hE0, 32'hF0);
    for (int i = 0; i < 4; i++) add(5'b00000, 32'h0, 4'b1000, 32'h0, 32'h0);
    add(5'b00000, 32'h0,  4'b0100, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      cyc($sformatf("row%0d", i), tbl[i].ctl, tbl[i].msg, tbl[i].ex, tbl[i].m0, tbl[i].m1);
    end

    // Random traffic; the last table row was cycle 4 after reset (domain-1 slot).
    m_cnt  = 1;
    m_slot = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ctl;
      logic [3:0] ex;
      logic [nb-1:0] msg;
      logic [nb-1:0] e0;
      logic [nb-1:0] e1;
      ctl = {1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      msg = $urandom;
      ex[3] = (ctl[2] == m_slot) && ((m_slot ? q1.size() : q0.size()) != 2);
      ex[2] = m_slot;
      ex[1] = (q0.size() != 0);
      ex[0] = (q1.size() != 0);
      e0 = (q0.size() != 0) ? q0[0] : 32'h0;
      e1 = (q1.size() != 0) ? q1[0] : 32'h0;
      cyc($sformatf("rnd%0d", i), ctl, msg, ex, e0, e1);
      if (m_cnt == ps - 1) begin
        m_cnt  = 0;
        m_slot = ~m_slot;
      end else begin
        m_cnt++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
